// File: rtl/loopback_tx_scheduler.sv
// Shares one UART transmitter between the serial echo path and a debounced
// switch-status reporter; owns all RX pop / TX push strobes and the LED mirror.
module loopback_tx_scheduler #(
  parameter logic [7:0]  REPORT_TAG    = 8'h53,
  parameter int unsigned STABLE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] switches,
  input  logic [7:0] rx_data,
  input  logic       rx_present,
  output logic       rx_read,
  output logic [7:0] tx_data,
  output logic       tx_write,
  input  logic       tx_full,
  output logic [7:0] leds,
  output logic       report_pending,
  output logic [2:0] dbg_state
);

  // Handshakes: an RX byte is consumed by the single-cycle rx_read pulse and
  // is valid whenever rx_present is high; a TX byte is pushed by the
  // single-cycle tx_write pulse, issued only when tx_full was low at the
  // edge that decided the write (IDLE or TGAP).
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ECHO = 3'd1,
    S_TAG  = 3'd2,
    S_TGAP = 3'd3,
    S_VAL  = 3'd4,
    S_GAP  = 3'd5
  } state_t;

  localparam logic [15:0] STABLE_MAX = 16'(STABLE_CYCLES);

  state_t      state_q, state_d;
  logic [7:0]  sync1_q, sync1_d;
  logic [7:0]  sync2_q, sync2_d;
  logic [7:0]  sample_q, sample_d;
  logic [15:0] stable_cnt_q, stable_cnt_d;
  logic [7:0]  ref_q, ref_d;
  logic [7:0]  pending_val_q, pending_val_d;
  logic        report_pending_q, report_pending_d;
  logic [7:0]  snap_q, snap_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_write_q, tx_write_d;
  logic        rx_read_q, rx_read_d;
  logic [7:0]  leds_q, leds_d;
  logic        last_rep_q, last_rep_d;
  logic        accept;
  logic        tag_grant;

  always_comb begin
    state_d          = state_q;
    sync1_d          = switches;
    sync2_d          = sync1_q;
    sample_d         = sync2_q;
    stable_cnt_d     = stable_cnt_q;
    ref_d            = ref_q;
    pending_val_d    = pending_val_q;
    report_pending_d = report_pending_q;
    snap_d           = snap_q;
    tx_data_d        = tx_data_q;
    tx_write_d       = 1'b0;
    rx_read_d        = 1'b0;
    leds_d           = leds_q;
    last_rep_d       = last_rep_q;
    tag_grant        = 1'b0;

    // Stability counter restarts on any sample-to-sample difference.
    if (sync2_q != sample_q) begin
      stable_cnt_d = 16'd0;
    end else if (stable_cnt_q < STABLE_MAX) begin
      stable_cnt_d = stable_cnt_q + 16'd1;
    end
    accept = (stable_cnt_d == STABLE_MAX) && (sample_q != ref_q);

    case (state_q)
      S_IDLE: begin
        if (!tx_full) begin
          if (rx_present && (!report_pending_q || last_rep_q)) begin
            state_d    = S_ECHO;
            tx_data_d  = rx_data;
            leds_d     = rx_data;
            rx_read_d  = 1'b1;
            tx_write_d = 1'b1;
            last_rep_d = 1'b0;
          end else if (report_pending_q) begin
            state_d    = S_TAG;
            tx_data_d  = REPORT_TAG;
            snap_d     = pending_val_q;
            tx_write_d = 1'b1;
            last_rep_d = 1'b1;
            tag_grant  = 1'b1;
          end
        end
      end
      S_ECHO: state_d = S_GAP;
      S_TAG:  state_d = S_TGAP;
      S_TGAP: begin
        if (!tx_full) begin
          state_d    = S_VAL;
          tx_data_d  = snap_q;
          tx_write_d = 1'b1;
        end
      end
      S_VAL:  state_d = S_GAP;
      S_GAP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // A change accepted on the grant edge wins, so it gets its own report.
    if (accept) begin
      ref_d            = sample_q;
      pending_val_d    = sample_q;
      report_pending_d = 1'b1;
    end else if (tag_grant) begin
      report_pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= S_IDLE;
      sync1_q          <= 8'h00;
      sync2_q          <= 8'h00;
      sample_q         <= 8'h00;
      stable_cnt_q     <= 16'd0;
      ref_q            <= 8'h00;
      pending_val_q    <= 8'h00;
      report_pending_q <= 1'b0;
      snap_q           <= 8'h00;
      tx_data_q        <= 8'h00;
      tx_write_q       <= 1'b0;
      rx_read_q        <= 1'b0;
      leds_q           <= 8'h00;
      last_rep_q       <= 1'b1;
    end else begin
      state_q          <= state_d;
      sync1_q          <= sync1_d;
      sync2_q          <= sync2_d;
      sample_q         <= sample_d;
      stable_cnt_q     <= stable_cnt_d;
      ref_q            <= ref_d;
      pending_val_q    <= pending_val_d;
      report_pending_q <= report_pending_d;
      snap_q           <= snap_d;
      tx_data_q        <= tx_data_d;
      tx_write_q       <= tx_write_d;
      rx_read_q        <= rx_read_d;
      leds_q           <= leds_d;
      last_rep_q       <= last_rep_d;
    end
  end

  assign rx_read        = rx_read_q;
  assign tx_data        = tx_data_q;
  assign tx_write       = tx_write_q;
  assign leds           = leds_q;
  assign report_pending = report_pending_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_loopback_tx_scheduler.sv
// Bench for loopback_tx_scheduler: reset checks, a cycle table, directed
// corner sequences and a randomized run against a transaction-level model.
module tb_loopback_tx_scheduler;

  localparam logic [7:0] TAG    = 8'h53;
  localparam int         STABLE = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] switches = 8'h00;
  logic [7:0] rx_data = 8'h00;
  logic       rx_present = 1'b0;
  logic       tx_full = 1'b0;
  logic       rx_read, tx_write, report_pending;
  logic [7:0] tx_data, leds;
  logic [2:0] dbg_state;

  always #5 clk = ~clk;

  loopback_tx_scheduler #(.REPORT_TAG(TAG), .STABLE_CYCLES(STABLE)) dut (
    .clk(clk), .reset(reset), .switches(switches),
    .rx_data(rx_data), .rx_present(rx_present), .rx_read(rx_read),
    .tx_data(tx_data), .tx_write(tx_write), .tx_full(tx_full),
    .leds(leds), .report_pending(report_pending), .dbg_state(dbg_state)
  );

  typedef struct {
    logic        rp;
    logic [7:0]  rd;
    logic        full;
    logic [17:0] exp;   // {rx_read, tx_write, tx_data, leds}
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic       echo;
  } wr_t;

  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         rd_cnt = 0;
  int         lone_rd = 0;
  logic [7:0] rx_buf[$];
  logic [7:0] exp_q[$];       // echo bytes in push order
  logic [7:0] exp_rep_q[$];   // report values in change order
  logic [8:0] exp_log[$];     // {echo, data} expected write stream
  wr_t        wlog[$];
  vec_t       vt[12];

  // random-phase model state
  bit         in_report = 0;
  bit         rep_busy = 0;
  int         since_rep = 100;
  logic       full_at_edge = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    rx_present = (rx_buf.size() != 0);
    if (rx_present) rx_data = rx_buf[0];
    else rx_data = 8'h00;
    @(posedge clk);
    #1;
    cyc++;
    if (tx_write) wlog.push_back('{tx_data, rx_read});
    if (rx_read) begin
      rd_cnt++;
      if (!tx_write) lone_rd++;
      if (rx_buf.size() != 0) void'(rx_buf.pop_front());
    end
  endtask

  task automatic wait_pending(input int lim, output int k);
    k = 0;
    for (int i = 1; i <= lim; i++) begin
      step();
      if (report_pending) begin
        k = i;
        break;
      end
    end
    if (k == 0) chk("pending_timeout", 0, 1);
  endtask

  task automatic wait_tag(input int lim);
    bit found = 0;
    for (int i = 0; i < lim; i++) begin
      step();
      if (tx_write && !rx_read) begin
        found = 1;
        break;
      end
    end
    chk("tag_seen", {31'd0, found}, 1);
    if (found) chk("tag_byte", {24'd0, tx_data}, {24'd0, TAG});
  endtask

  task automatic compare_log(input string name);
    int n;
    chk({name, "_len"}, wlog.size(), exp_log.size());
    n = (wlog.size() < exp_log.size()) ? wlog.size() : exp_log.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_w%0d", name, i), {23'd0, wlog[i].echo, wlog[i].data}, {23'd0, exp_log[i]});
  endtask

  // One randomized cycle, checked against the stream-level rules.
  task automatic rand_cycle(input bit allow_new);
    logic [7:0] nv;
    logic [7:0] e;
    if (allow_new && rx_buf.size() < 8 && $urandom_range(0, 3) == 0) begin
      nv = 8'($urandom_range(0, 255));
      rx_buf.push_back(nv);
      exp_q.push_back(nv);
    end
    tx_full = allow_new ? ($urandom_range(0, 9) < 3) : 1'b0;
    if (allow_new && !rep_busy && since_rep >= 5 && $urandom_range(0, 99) == 0) begin
      do nv = 8'($urandom_range(0, 255)); while (nv == switches);
      switches = nv;
      exp_rep_q.push_back(nv);
      rep_busy = 1;
    end
    full_at_edge = tx_full;
    step();
    since_rep++;
    if (rx_read && !tx_write) chk("rnd_lone_read", 1, 0);
    if (tx_write) begin
      chk("rnd_write_when_full", {31'd0, full_at_edge}, 0);
      if (rx_read) begin
        chk("rnd_echo_split_report", {31'd0, in_report}, 0);
        if (exp_q.size() == 0) chk("rnd_echo_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("rnd_echo_data", {24'd0, tx_data}, {24'd0, e});
          chk("rnd_leds", {24'd0, leds}, {24'd0, e});
        end
      end else if (!in_report) begin
        chk("rnd_tag", {24'd0, tx_data}, {24'd0, TAG});
        in_report = 1;
      end else begin
        if (exp_rep_q.size() == 0) chk("rnd_report_unexpected", 1, 0);
        else chk("rnd_report_val", {24'd0, tx_data}, {24'd0, exp_rep_q.pop_front()});
        in_report = 0;
        rep_busy = 0;
        since_rep = 0;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k, nz, t0, found;

    vt[0]  = '{1'b1, 8'h41, 1'b1, {2'b00, 8'h00, 8'h00}};
    vt[1]  = '{1'b1, 8'h41, 1'b0, {2'b11, 8'h41, 8'h41}};
    vt[2]  = '{1'b0, 8'h00, 1'b0, {2'b00, 8'h41, 8'h41}};
    vt[3]  = '{1'b1, 8'h42, 1'b0, {2'b00, 8'h41, 8'h41}};
    vt[4]  = '{1'b1, 8'h42, 1'b0, {2'b11, 8'h42, 8'h42}};
    vt[5]  = '{1'b1, 8'h43, 1'b0, {2'b00, 8'h42, 8'h42}};
    vt[6]  = '{1'b1, 8'h43, 1'b1, {2'b00, 8'h42, 8'h42}};
    vt[7]  = '{1'b1, 8'h43, 1'b1, {2'b00, 8'h42, 8'h42}};
    vt[8]  = '{1'b1, 8'h43, 1'b0, {2'b11, 8'h43, 8'h43}};
    vt[9]  = '{1'b0, 8'h00, 1'b0, {2'b00, 8'h43, 8'h43}};
    vt[10] = '{1'b0, 8'h00, 1'b0, {2'b00, 8'h43, 8'h43}};
    vt[11] = '{1'b0, 8'h00, 1'b0, {2'b00, 8'h43, 8'h43}};

    // ---- reset ----
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {13'd0, rx_read, tx_write, tx_data, leds, report_pending}, 0);
    chk("reset_state", {29'd0, dbg_state}, 0);
    reset = 1'b0;
    nz = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if ({rx_read, tx_write, tx_data, leds, report_pending} != 0) nz++;
    end
    chk("idle_100_cycles", nz, 0);

    // ---- cycle table: echo timing, spacing, tx_full gating ----
    for (int i = 0; i < 12; i++) begin
      rx_present = vt[i].rp;
      rx_data    = vt[i].rd;
      tx_full    = vt[i].full;
      @(posedge clk);
      #1;
      cyc++;
      chk($sformatf("vec%0d", i), {14'd0, rx_read, tx_write, tx_data, leds}, {14'd0, vt[i].exp});
    end
    rx_present = 1'b0;
    tx_full = 1'b0;

    // ---- switch report 00 -> A5 ----
    wlog.delete();
    switches = 8'hA5;
    wait_pending(40, k);
    chk("pending_latency_ok", {31'd0, (k >= STABLE + 2 && k <= STABLE + 3)}, 1);
    t0 = cyc;
    found = -1;
    for (int i = 0; i < 8; i++) begin
      step();
      if (tx_write && found < 0) found = cyc - t0;
      if (tx_write && !rx_read && tx_data == 8'hA5) chk("report_gap", cyc - t0 - found, 2);
    end
    exp_log.delete();
    exp_log.push_back({1'b0, TAG});
    exp_log.push_back({1'b0, 8'hA5});
    compare_log("report_a5");
    chk("leds_kept", {24'd0, leds}, 32'h43);

    // ---- echo + report together: alternation ----
    tx_full = 1'b1;
    switches = 8'h3C;
    wait_pending(40, k);
    rx_buf = '{8'h31, 8'h32, 8'h33};
    wlog.delete();
    tx_full = 1'b0;
    repeat (25) step();
    exp_log = '{{1'b1, 8'h31}, {1'b0, TAG}, {1'b0, 8'h3C}, {1'b1, 8'h32}, {1'b1, 8'h33}};
    compare_log("alt1");
    tx_full = 1'b1;
    switches = 8'hC3;
    wait_pending(40, k);
    rx_buf = '{8'h34};
    wlog.delete();
    tx_full = 1'b0;
    repeat (15) step();
    exp_log = '{{1'b0, TAG}, {1'b0, 8'hC3}, {1'b1, 8'h34}};
    compare_log("alt2");

    // ---- tx_full held with rx_present ----
    tx_full = 1'b1;
    rx_buf = '{8'h5A};
    wlog.delete();
    k = rd_cnt;
    repeat (50) step();
    chk("full_no_write", wlog.size(), 0);
    chk("full_no_read", rd_cnt - k, 0);
    tx_full = 1'b0;
    for (int i = 0; i < 2 && wlog.size() == 0; i++) step();
    chk("release_echo_len", wlog.size(), 1);
    if (wlog.size() != 0) chk("release_echo", {23'd0, wlog[0].echo, wlog[0].data}, {23'd0, 1'b1, 8'h5A});
    repeat (3) step();

    // ---- tx_full during TGAP ----
    switches = 8'h66;
    wait_tag(40);
    tx_full = 1'b1;
    wlog.delete();
    repeat (10) step();
    chk("tgap_hold_no_write", wlog.size(), 0);
    tx_full = 1'b0;
    for (int i = 0; i < 2 && wlog.size() == 0; i++) step();
    chk("tgap_val_len", wlog.size(), 1);
    if (wlog.size() != 0) chk("tgap_val", {24'd0, wlog[0].data}, 32'h66);
    repeat (3) step();

    // ---- glitch shorter than STABLE_CYCLES ----
    wlog.delete();
    nz = 0;
    switches = 8'h99;
    repeat (5) begin step(); if (report_pending) nz++; end
    switches = 8'h66;
    repeat (40) begin step(); if (report_pending) nz++; end
    chk("glitch_no_pending", nz, 0);
    chk("glitch_no_write", wlog.size(), 0);

    // ---- reset during TGAP abandons the report ----
    switches = 8'hA5;
    wait_tag(40);
    step();
    chk("in_tgap", {29'd0, dbg_state}, 3);
    reset = 1'b1;
    #1;
    chk("reset_async_state", {29'd0, dbg_state}, 0);
    chk("reset_async_write", {31'd0, tx_write}, 0);
    wlog.delete();
    repeat (2) step();
    reset = 1'b0;
    repeat (40) step();
    exp_log = '{{1'b0, TAG}, {1'b0, 8'hA5}};
    compare_log("rereport");

    chk("no_lone_read", lone_rd, 0);

    // ---- randomized run ----
    for (int i = 0; i < 3000; i++) rand_cycle(1'b1);
    for (int i = 0; i < 300; i++) rand_cycle(1'b0);
    chk("rnd_echo_drained", exp_q.size(), 0);
    chk("rnd_reports_drained", exp_rep_q.size(), 0);
    chk("rnd_report_complete", {31'd0, in_report}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/loopback_tx_scheduler.md
# loopback_tx_scheduler

Sequencer that shares the single UART transmitter of the loopback design between two requesters: the serial echo path (bytes popped from the UART receive buffer) and a switch-status reporter (a two-byte tag/value message sent whenever the debounced switch bank changes). It sits between the UART RX buffer, the UART TX buffer and the board switches/LEDs. It owns all buffer read/write strobes, guarantees that no received byte is lost and that report messages are never split, and mirrors the last echoed byte on the LEDs.

## Interface
- REPORT_TAG, 8'h53, first byte of every switch report ('S')
- STABLE_CYCLES, 16, consecutive equal synchronized samples required before a switch change is accepted (2..65535)
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-high reset
- switches  input  8  raw board switches, asynchronous to clk
- rx_data  input  8  byte at head of UART RX buffer
- rx_present  input  1  RX buffer non-empty
- rx_read  output  1  one-cycle pop strobe to RX buffer
- tx_data  output  8  byte presented to UART TX buffer
- tx_write  output  1  one-cycle push strobe to TX buffer
- tx_full  input  1  TX buffer full
- leds  output  8  last echoed byte
- report_pending  output  1  debounced switch change accepted, report not yet started

## Operation
- All outputs registered. Reset values: rx_read=0, tx_write=0, tx_data=8'h00, leds=8'h00, report_pending=0; FSM in IDLE; reported-switch reference=8'h00; round-robin pointer = "report served last".
- Switch path: 2-flop synchronizer; stability counter (16 bits, saturating at STABLE_CYCLES) clears whenever the synchronized value differs from the previous sample. When counter reaches STABLE_CYCLES and the sample differs from the reference: reference <= sample, pending value <= sample, report_pending <= 1. A further accepted change while pending overwrites the pending value (latest wins, one report).
- FSM states: IDLE, ECHO, TAG, TGAP, VAL, GAP.
- IDLE: candidates are echo (rx_present=1) and report (report_pending=1). Requires tx_full=0 to grant anything. Both present: grant the one not served last; pointer updated on grant.
- IDLE->ECHO: tx_data <= rx_data, leds <= rx_data. In ECHO: rx_read=1 and tx_write=1 for exactly that cycle. ECHO->GAP.
- IDLE->TAG: tx_data <= REPORT_TAG, snapshot <= pending value, report_pending <= 0 (same edge). In TAG: tx_write=1. TAG->TGAP.
- TGAP: wait while tx_full=1; else tx_data <= snapshot, ->VAL. In VAL: tx_write=1. VAL->GAP.
- GAP: one idle cycle so buffer flags settle; ->IDLE.
- tx_data holds its last value outside write cycles; leds change only on echo.
- Echo bytes never dropped: rx_read only coincident with tx_write. Report tag and value always adjacent in TX stream; no echo inserted between them.
- Reset at any time: strobes drop immediately, FSM to IDLE, partially sent report (TAG without VAL) abandoned, reference back to 8'h00 (a non-zero switch setting is re-reported after reset).

## Timing
- Echo latency: rx_present=1 sampled in IDLE at edge N -> rx_read/tx_write high in cycle N..N+1; next grant no earlier than 3 cycles after previous grant (ECHO, GAP, IDLE).
- Max throughput: one echoed byte per 3 cycles; full report occupies 5 cycles minimum (TAG, TGAP, VAL, GAP, IDLE).
- Switch change to report_pending: STABLE_CYCLES+2 to STABLE_CYCLES+3 cycles after a clean switch edge.
- tx_full sampled only in IDLE and TGAP; never a write while tx_full was 1 at the deciding edge.
- Simultaneous report_pending set and TAG grant on same edge: grant uses old pending value; new change leaves report_pending=1 for a second report.

## Test plan
- Reset with switches=8'h00, rx_present=0 -> all outputs 0 for 100 cycles, no strobes.
- rx_data=8'h41, rx_present=1 for one byte -> single cycle with rx_read=1, tx_write=1, tx_data=8'h41; leds=8'h41 thereafter.
- switches 8'h00->8'hA5 (STABLE_CYCLES=16) -> report_pending within 18-19 cycles; TX stream 8'h53 then 8'hA5, tx_write pulses 2 cycles apart.
- Echo of 8'h31 pending with report pending together -> strict alternation; report bytes 8'h53,value adjacent; second-round priority flips.
- tx_full=1 held 50 cycles with rx_present=1 -> zero rx_read/tx_write; release -> echo within 2 cycles, byte intact; tx_full asserted in TGAP -> VAL delayed until release.
- Switch glitch shorter than STABLE_CYCLES -> no report; reset asserted during TGAP -> no VAL write, FSM IDLE, switches 8'hA5 re-reported after release.
